// File: rtl/tff_down_counter.sv
// ---------------------------------------------------------------------------
// tff_down_counter
//
// Synchronous loadable down-counter / timer. A start value is loaded and
// counted down to zero on enabled clocks. Terminal count is flagged with a
// one-cycle registered pulse. This is the programmable delay / timeout
// element that sits beside the up-counter in the counter subsystem.
//
// Parameters:
//   WIDTH  counter and load-value width in bits (legal range 2..16)
//
// Ports:
//   C     in   1      clock, all state changes on the rising edge
//   R     in   1      synchronous reset, active-high (beats LD and EN)
//   LD    in   1      load strobe, samples D (beats EN)
//   D     in   WIDTH  load value
//   EN    in   1      count enable, one decrement per enabled edge
//   Q     out  WIDTH  current count (registered)
//   TC    out  1      terminal-count pulse (registered)
//   BUSY  out  1      high while the FSM is in COUNT (registered)
//
// Build option:
//   TFF_DOWN_COUNTER_AUTO_RELOAD_EN
//     undefined : DONE always returns to IDLE on the next edge.
//     defined   : a reload register RLD keeps the last loaded value. From
//                 DONE, an enabled edge reloads Q from RLD and keeps counting
//                 (periodic TC every RLD+1 enabled cycles). If RLD is zero the
//                 enabled edge returns to IDLE instead. With EN low the FSM
//                 waits in DONE.
//
// State table:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no count in progress, Q is 0, EN ignored
//   ST_COUNT | counting down, Q holds the remaining enabled cycles (>0)
//   ST_DONE  | Q reached 0 on the previous edge; TC was raised on entry
// ---------------------------------------------------------------------------
module tff_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic             tc_q,    tc_d;
  logic             busy_q,  busy_d;

`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] rld_q,   rld_d;
`endif

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // TC is a pulse: it only survives one edge unless re-raised below.
    tc_d    = 1'b0;
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
    rld_d   = rld_q;
`endif

    if (LD) begin
      // A load is accepted from every state and behaves the same everywhere;
      // a zero load expires immediately instead of entering COUNT.
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
      rld_d = D;
`endif
      if (D != CNT_ZERO) begin
        cnt_d   = D;
        state_d = ST_COUNT;
      end else begin
        cnt_d   = CNT_ZERO;
        state_d = ST_DONE;
        tc_d    = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          // EN has no effect here; Q stays parked at zero and never wraps.
          state_d = ST_IDLE;
        end

        ST_COUNT: begin
          if (EN) begin
            // Q is never 0 in COUNT, so the decrement cannot underflow.
            if (cnt_q > CNT_ONE) begin
              cnt_d = cnt_q - CNT_ONE;
            end else begin
              cnt_d   = CNT_ZERO;
              state_d = ST_DONE;
              tc_d    = 1'b1;
            end
          end
        end

        ST_DONE: begin
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
          if (EN) begin
            if (rld_q != CNT_ZERO) begin
              cnt_d   = rld_q;
              state_d = ST_COUNT;
            end else begin
              state_d = ST_IDLE;
            end
          end
`else
          state_d = ST_IDLE;
`endif
        end

        default: begin
          // Unused encoding: recover to a clean idle.
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    // BUSY is registered from the next state so it lines up with Q.
    busy_d = (state_d == ST_COUNT);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
  always_ff @(posedge C) begin
    if (R) begin
      rld_q <= CNT_ZERO;
    end else begin
      rld_q <= rld_d;
    end
  end
`endif

  assign Q    = cnt_q;
  assign TC   = tc_q;
  assign BUSY = busy_q;

  // A running count is never zero; catching this early points at a broken
  // decrement or load path.
  a_busy_nonzero : assert property (@(posedge C) disable iff (R)
    BUSY |-> (Q != CNT_ZERO));

endmodule
